mem_wb_pipe_reg: RTL and testbench

Parametrised MEM→WB pipeline register, successor to the fixed-width MEM/WB latch. It carries the Control/ReadData/ADDR/RegDst/PC/SHIFT bundle using valid/ready flow control and a 2-entry skid buffer, so back-pressure from WB never drops an instruction. It supports a synchronous flush that inserts bubbles, with Control zeroed to a NOP. Saturating stall and flush counters are exported for performance debug.

---
 rtl/mem_wb_pipe_reg.sv | 115 +++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush to a NOP bubble, and saturating stall/flush counters.
module mem_wb_pipe_reg #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CTRL_W-1:0] I_MEMWB_Control,
    input  logic [DATA_W-1:0] I_MEMWB_ReadData,
    input  logic [DATA_W-1:0] I_MEMWB_ADDR,
    input  logic [REG_W-1:0]  I_MEMWB_RegDst,
    input  logic [DATA_W-1:0] I_MEMWB_PC,
    input  logic [DATA_W-1:0] I_MEMWB_SHIFT,
    input  logic              I_VALID,
    output logic              O_READY,
    input  logic              I_READY,
    input  logic              I_FLUSH,
    output logic              O_VALID,
    output logic [CTRL_W-1:0] O_MEMWB_Control,
    output logic [DATA_W-1:0] O_MEMWB_ReadData,
    output logic [DATA_W-1:0] O_MEMWB_ADDR,
    output logic [REG_W-1:0]  O_MEMWB_RegDst,
    output logic [DATA_W-1:0] O_MEMWB_PC,
    output logic [DATA_W-1:0] O_MEMWB_SHIFT,
    output logic [CNT_W-1:0]  O_STALL_CNT,
    output logic [CNT_W-1:0]  O_FLUSH_CNT
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] addr;
        logic [REG_W-1:0]  regdst;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] shift;
    } bundle_t;

    bundle_t          in_b;
    bundle_t          main_q;
    bundle_t          skid_q;
    logic             main_v;
    logic             skid_v;
    logic             acc;
    logic             pop;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign in_b = '{ctrl:   I_MEMWB_Control,
                    rdata:  I_MEMWB_ReadData,
                    addr:   I_MEMWB_ADDR,
                    regdst: I_MEMWB_RegDst,
                    pc:     I_MEMWB_PC,
                    shift:  I_MEMWB_SHIFT};

    // Ready depends only on registered skid state, never on I_READY.
    assign O_READY = ~skid_v;
    assign O_VALID = main_v;
    assign acc     = I_VALID & O_READY;
    assign pop     = main_v & I_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (I_FLUSH) begin
            main_v      <= 1'b0;
            skid_v      <= 1'b0;
            main_q.ctrl <= '0;
        end else if (!main_v || pop) begin
            if (skid_v) begin
                // Older skid entry goes first; a same-cycle arrival backfills skid.
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= acc;
                if (acc) skid_q <= in_b;
            end else if (acc) begin
                main_q <= in_b;
                main_v <= 1'b1;
            end else begin
                main_v      <= 1'b0;
                main_q.ctrl <= '0;
            end
        end else if (acc) begin
            skid_q <= in_b;
            skid_v <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_v && !I_READY && !I_FLUSH && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (I_FLUSH && (main_v || skid_v) && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign O_MEMWB_Control  = main_q.ctrl;
    assign O_MEMWB_ReadData = main_q.rdata;
    assign O_MEMWB_ADDR     = main_q.addr;
    assign O_MEMWB_RegDst   = main_q.regdst;
    assign O_MEMWB_PC       = main_q.pc;
    assign O_MEMWB_SHIFT    = main_q.shift;
    assign O_STALL_CNT      = stall_cnt;
    assign O_FLUSH_CNT      = flush_cnt;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mem_wb_pipe_reg;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [19:0] I_MEMWB_Control = '0;
    logic [31:0] I_MEMWB_ReadData = '0;
    logic [31:0] I_MEMWB_ADDR = '0;
    logic [4:0]  I_MEMWB_RegDst = '0;
    logic [31:0] I_MEMWB_PC = '0;
    logic [31:0] I_MEMWB_SHIFT = '0;
    logic        I_VALID = 1'b0;
    logic        I_READY = 1'b1;
    logic        I_FLUSH = 1'b0;

    logic        O_READY, O_VALID;
    logic [19:0] O_MEMWB_Control;
    logic [31:0] O_MEMWB_ReadData, O_MEMWB_ADDR, O_MEMWB_PC, O_MEMWB_SHIFT;
    logic [4:0]  O_MEMWB_RegDst;
    logic [15:0] O_STALL_CNT, O_FLUSH_CNT;

    logic        r4, v4;
    logic [19:0] c4;
    logic [31:0] rd4, a4, pc4, s4;
    logic [4:0]  rg4;
    logic [3:0]  st4, fl4;

    always #5 CLK = ~CLK;

    mem_wb_pipe_reg dut (
        .CLK(CLK), .RESET(RESET),
        .I_MEMWB_Control(I_MEMWB_Control), .I_MEMWB_ReadData(I_MEMWB_ReadData),
        .I_MEMWB_ADDR(I_MEMWB_ADDR), .I_MEMWB_RegDst(I_MEMWB_RegDst),
        .I_MEMWB_PC(I_MEMWB_PC), .I_MEMWB_SHIFT(I_MEMWB_SHIFT),
        .I_VALID(I_VALID), .O_READY(O_READY), .I_READY(I_READY), .I_FLUSH(I_FLUSH),
        .O_VALID(O_VALID), .O_MEMWB_Control(O_MEMWB_Control),
        .O_MEMWB_ReadData(O_MEMWB_ReadData), .O_MEMWB_ADDR(O_MEMWB_ADDR),
        .O_MEMWB_RegDst(O_MEMWB_RegDst), .O_MEMWB_PC(O_MEMWB_PC),
        .O_MEMWB_SHIFT(O_MEMWB_SHIFT), .O_STALL_CNT(O_STALL_CNT), .O_FLUSH_CNT(O_FLUSH_CNT)
    );

    mem_wb_pipe_reg #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET),
        .I_MEMWB_Control(I_MEMWB_Control), .I_MEMWB_ReadData(I_MEMWB_ReadData),
        .I_MEMWB_ADDR(I_MEMWB_ADDR), .I_MEMWB_RegDst(I_MEMWB_RegDst),
        .I_MEMWB_PC(I_MEMWB_PC), .I_MEMWB_SHIFT(I_MEMWB_SHIFT),
        .I_VALID(I_VALID), .O_READY(r4), .I_READY(I_READY), .I_FLUSH(I_FLUSH),
        .O_VALID(v4), .O_MEMWB_Control(c4), .O_MEMWB_ReadData(rd4),
        .O_MEMWB_ADDR(a4), .O_MEMWB_RegDst(rg4), .O_MEMWB_PC(pc4),
        .O_MEMWB_SHIFT(s4), .O_STALL_CNT(st4), .O_FLUSH_CNT(fl4)
    );

    typedef struct packed {
        logic [19:0] ctrl;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [4:0]  regdst;
        logic [31:0] pc;
        logic [31:0] shift;
    } bun_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every field derives from PC so any split or reorder of a bundle shows up.
    function automatic bun_t mk(input logic [31:0] pc);
        bun_t b;
        b.ctrl   = pc[19:0] ^ 20'h5A5A5;
        b.rdata  = pc * 3;
        b.addr   = pc + 32'd1;
        b.regdst = pc[6:2];
        b.pc     = pc;
        b.shift  = ~pc;
        return b;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        bun_t b;
        b = mk(pc);
        I_VALID          = v;
        I_MEMWB_Control  = b.ctrl;
        I_MEMWB_ReadData = b.rdata;
        I_MEMWB_ADDR     = b.addr;
        I_MEMWB_RegDst   = b.regdst;
        I_MEMWB_PC       = b.pc;
        I_MEMWB_SHIFT    = b.shift;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: an ordered list of at most two held bundles.
    bun_t mq[$];
    bun_t mlast;
    int   mstall, mstall4, mflush, mflush4;
    bit   started = 0;

    always @(posedge CLK) begin : model
        bit rdy;
        bit vld;
        bun_t inb;
        inb = '{ctrl: I_MEMWB_Control, rdata: I_MEMWB_ReadData, addr: I_MEMWB_ADDR,
                regdst: I_MEMWB_RegDst, pc: I_MEMWB_PC, shift: I_MEMWB_SHIFT};
        if (RESET) begin
            mq.delete();
            mlast   = '0;
            mstall  = 0; mstall4 = 0; mflush = 0; mflush4 = 0;
        end else if (I_FLUSH) begin
            if (mq.size() > 0) begin
                if (mflush < 65535) mflush++;
                if (mflush4 < 15) mflush4++;
            end
            mq.delete();
        end else begin
            rdy = mq.size() < 2;
            vld = mq.size() > 0;
            if (vld && !I_READY) begin
                if (mstall < 65535) mstall++;
                if (mstall4 < 15) mstall4++;
            end
            if (vld && I_READY) void'(mq.pop_front());
            if (I_VALID && rdy) mq.push_back(inb);
        end
        if (mq.size() > 0) mlast = mq[0];
        else mlast.ctrl = '0;
        started = 1;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("valid", {63'd0, O_VALID}, {63'd0, mq.size() > 0});
            chk("ready", {63'd0, O_READY}, {63'd0, mq.size() < 2});
            chk("ctrl", {44'd0, O_MEMWB_Control}, {44'd0, mlast.ctrl});
            chk("rdata", {32'd0, O_MEMWB_ReadData}, {32'd0, mlast.rdata});
            chk("addr", {32'd0, O_MEMWB_ADDR}, {32'd0, mlast.addr});
            chk("regdst", {59'd0, O_MEMWB_RegDst}, {59'd0, mlast.regdst});
            chk("pc", {32'd0, O_MEMWB_PC}, {32'd0, mlast.pc});
            chk("shift", {32'd0, O_MEMWB_SHIFT}, {32'd0, mlast.shift});
            chk("stall_cnt", {48'd0, O_STALL_CNT}, 64'(mstall));
            chk("flush_cnt", {48'd0, O_FLUSH_CNT}, 64'(mflush));
            chk("valid4", {63'd0, v4}, {63'd0, mq.size() > 0});
            chk("ready4", {63'd0, r4}, {63'd0, mq.size() < 2});
            chk("pc4", {32'd0, pc4}, {32'd0, mlast.pc});
            chk("ctrl4", {44'd0, c4}, {44'd0, mlast.ctrl});
            chk("stall_cnt4", {60'd0, st4}, 64'(mstall4));
            chk("flush_cnt4", {60'd0, fl4}, 64'(mflush4));
        end
    end

    initial begin
        // Reset held for two edges.
        RESET = 1; I_READY = 1; drive(0, 0);
        step(); step();
        chk("rst_valid", {63'd0, O_VALID}, 64'd0);
        chk("rst_ready", {63'd0, O_READY}, 64'd1);
        chk("rst_pc", {32'd0, O_MEMWB_PC}, 64'd0);
        chk("rst_ctrl", {44'd0, O_MEMWB_Control}, 64'd0);
        chk("rst_stall", {48'd0, O_STALL_CNT}, 64'd0);
        RESET = 0;

        // Stream four bundles, one-cycle latency, no gaps.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(4 * i));
            step();
            chk("stream_valid", {63'd0, O_VALID}, 64'd1);
            chk("stream_pc", {32'd0, O_MEMWB_PC}, 64'h100 + 64'(4 * i));
        end
        drive(0, 0); step();
        chk("drain_valid", {63'd0, O_VALID}, 64'd0);
        chk("drain_ctrl", {44'd0, O_MEMWB_Control}, 64'd0);

        // Back-pressure: 0x104 held in main, 0x108 in skid, 0x10C waits upstream.
        drive(1, 32'h100); step();
        drive(1, 32'h104); step();
        I_READY = 0;
        drive(1, 32'h108); step();
        drive(1, 32'h10C); step(); step();
        chk("bp_pc", {32'd0, O_MEMWB_PC}, 64'h104);
        chk("bp_ready", {63'd0, O_READY}, 64'd0);
        chk("bp_stall", {48'd0, O_STALL_CNT}, 64'd3);

        // Release with I_VALID still high: skid entry goes out first.
        I_READY = 1; step();
        chk("rel_pc", {32'd0, O_MEMWB_PC}, 64'h108);
        chk("rel_ready", {63'd0, O_READY}, 64'd1);
        step();
        chk("rel_pc2", {32'd0, O_MEMWB_PC}, 64'h10C);

        // Flush with main and skid both full and 0x200 offered.
        I_READY = 0;
        drive(1, 32'h110); step();
        chk("pre_flush_ready", {63'd0, O_READY}, 64'd0);
        drive(1, 32'h200); I_FLUSH = 1; step();
        chk("fl_valid", {63'd0, O_VALID}, 64'd0);
        chk("fl_ctrl", {44'd0, O_MEMWB_Control}, 64'd0);
        chk("fl_ready", {63'd0, O_READY}, 64'd1);
        chk("fl_cnt", {48'd0, O_FLUSH_CNT}, 64'd1);
        chk("fl_stall", {48'd0, O_STALL_CNT}, 64'd4);
        I_FLUSH = 0; drive(0, 0); step();
        I_FLUSH = 1; step();
        chk("fl_empty_cnt", {48'd0, O_FLUSH_CNT}, 64'd1);
        I_FLUSH = 0;

        // Reset while stalled with both entries valid.
        drive(1, 32'h300); step();
        drive(1, 32'h304); step();
        RESET = 1; step();
        chk("mr_valid", {63'd0, O_VALID}, 64'd0);
        chk("mr_ready", {63'd0, O_READY}, 64'd1);
        chk("mr_pc", {32'd0, O_MEMWB_PC}, 64'd0);
        chk("mr_stall", {48'd0, O_STALL_CNT}, 64'd0);
        chk("mr_flush", {48'd0, O_FLUSH_CNT}, 64'd0);
        RESET = 0;

        // Saturation: 20 stalled cycles on the 4-bit counter instance.
        drive(1, 32'h400); step();
        drive(0, 0);
        repeat (20) step();
        chk("sat_stall16", {48'd0, O_STALL_CNT}, 64'd20);
        chk("sat_stall4", {60'd0, st4}, 64'd15);

        // Randomized soak, model-checked every cycle.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom);
            I_READY = ($urandom % 3) != 0;
            I_FLUSH = ($urandom % 25) == 0;
            step();
        end
        I_FLUSH = 0; drive(0, 0); I_READY = 1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
